// File: rtl/ika9958_vram_slot_arbiter.sv
// VRAM access-slot arbiter: assigns each slot to display, refresh, CPU or command engine,
// holds the grant for SLOT_LEN enabled cycles and acks CPU/command on the last slot cycle.
module ika9958_vram_slot_arbiter #(
    parameter int unsigned SLOT_LEN   = 8,
    parameter int unsigned CMD_STARVE = 2
) (
    input  logic       i_phiA,
    input  logic       i_HRST_n,
    input  logic       i_phiA_NCEN,
    input  logic       i_slot_start,
    input  logic [1:0] i_slot_type,
    input  logic       i_disp_en,
    input  logic       i_cpu_req,
    input  logic       i_cpu_wr,
    input  logic       i_cmd_req,
    input  logic       i_cmd_wr,
    output logic [3:0] o_gnt,
    output logic       o_we,
    output logic       o_cpu_ack,
    output logic       o_cmd_ack,
    output logic       o_busy,
    output logic       o_ovr
);

    localparam logic [3:0] CNT_LOAD   = 4'(SLOT_LEN - 1);
    localparam logic [3:0] STARVE_LIM = 4'(CMD_STARVE);

    localparam logic [3:0] GNT_DISP = 4'b0001;
    localparam logic [3:0] GNT_RFSH = 4'b0010;
    localparam logic [3:0] GNT_CPU  = 4'b0100;
    localparam logic [3:0] GNT_CMD  = 4'b1000;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] starve_q;
    logic [3:0] gnt_q;
    logic       we_q;
    logic       cpu_ack_q;
    logic       cmd_ack_q;
    logic       ovr_q;

    logic       free_slot;
    logic       cmd_win;
    logic       cpu_win;
    logic       slot_go;
    logic [3:0] gnt_d;
    logic       we_d;
    logic [3:0] starve_d;

    // Owner decision for a slot starting on this edge; only consumed when slot_go is set.
    always_comb begin
        free_slot = (i_slot_type == 2'b00) || ((i_slot_type != 2'b10) && !i_disp_en);
        cmd_win   = free_slot && i_cmd_req && (!i_cpu_req || (starve_q >= STARVE_LIM));
        cpu_win   = free_slot && i_cpu_req && !cmd_win;
        slot_go   = i_slot_start && ((state_q == IDLE) || (cnt_q == '0));

        gnt_d = '0;
        we_d  = 1'b0;
        if (i_slot_type == 2'b10) begin
            gnt_d = GNT_RFSH;
        end else if (!free_slot) begin
            gnt_d = GNT_DISP;
        end else if (cmd_win) begin
            gnt_d = GNT_CMD;
            we_d  = i_cmd_wr;
        end else if (cpu_win) begin
            gnt_d = GNT_CPU;
            we_d  = i_cpu_wr;
        end

        starve_d = starve_q;
        if (!i_cmd_req || cmd_win) begin
            starve_d = '0;
        end else if (cpu_win && (starve_q != '1)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge i_phiA or negedge i_HRST_n) begin
        if (!i_HRST_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            starve_q  <= '0;
            gnt_q     <= '0;
            we_q      <= 1'b0;
            cpu_ack_q <= 1'b0;
            cmd_ack_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else if (i_phiA_NCEN) begin
            if (slot_go) begin
                state_q   <= ACCESS;
                cnt_q     <= CNT_LOAD;
                gnt_q     <= gnt_d;
                we_q      <= we_d;
                starve_q  <= starve_d;
                cpu_ack_q <= 1'b0;
                cmd_ack_q <= 1'b0;
            end else if (state_q == ACCESS) begin
                if (cnt_q == '0) begin
                    state_q   <= IDLE;
                    gnt_q     <= '0;
                    we_q      <= 1'b0;
                    cpu_ack_q <= 1'b0;
                    cmd_ack_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                    // Ack is registered one edge early so it lines up with cnt==0.
                    cpu_ack_q <= (cnt_q == 4'd1) && gnt_q[2];
                    cmd_ack_q <= (cnt_q == 4'd1) && gnt_q[3];
                    if (i_slot_start) begin
                        ovr_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_gnt     = gnt_q;
    assign o_we      = we_q;
    assign o_cpu_ack = cpu_ack_q;
    assign o_cmd_ack = cmd_ack_q;
    assign o_busy    = (state_q == ACCESS);
    assign o_ovr     = ovr_q;

endmodule

// File: doc/ika9958_vram_slot_arbiter.md
# ika9958_vram_slot_arbiter

Schedules VRAM access slots between the display fetcher, DRAM refresh, the CPU port and the command engine. The screen timing generator marks slot boundaries and slot types. This block decides the owner of each slot, holds the grant for the slot duration and returns completion acks to the CPU and command requesters. It sits between screen timing and the VRAM address/data mux, and has no knowledge of addresses or data.

## Interface
Parameters:
- SLOT_LEN, 8: enabled cycles per access slot (legal range 2..15).
- CMD_STARVE, 2: consecutive free slots the CPU may win while a command request waits; the next free slot then goes to the command engine.

Ports:
- i_phiA  in  1  clock.
- i_HRST_n  in  1  reset, asynchronous, active-low.
- i_phiA_NCEN  in  1  clock enable; all state advances only on i_phiA edges with i_phiA_NCEN=1.
- i_slot_start  in  1  first cycle of a slot (sampled on enabled edges only).
- i_slot_type  in  2  slot type: 00 free, 01 display, 10 refresh, 11 treated as display.
- i_disp_en  in  1  display enable; 0 turns display slots into free slots.
- i_cpu_req / i_cpu_wr  in  1/1  CPU access request and write flag.
- i_cmd_req / i_cmd_wr  in  1/1  command engine access request and write flag.
- o_gnt  out  4  one-hot owner {cmd,cpu,rfsh,disp}; 0 when idle or when a free slot has no taker.
- o_we  out  1  write strobe for the active slot.
- o_cpu_ack / o_cmd_ack  out  1/1  one-enabled-cycle completion pulse.
- o_busy  out  1  slot in progress.
- o_ovr  out  1  sticky overrun flag.

## Operation
- States:
  - IDLE: o_busy=0, o_gnt=0.
  - ACCESS: o_busy=1, down-counter cnt active.
- Owner is decided on an enabled edge where i_slot_start=1 and the block is in IDLE, or in ACCESS with cnt==0:
  - type 01/11 with i_disp_en=1 → disp.
  - type 10 → rfsh, regardless of i_disp_en.
  - free slot (type 00, or display with i_disp_en=0):
    - cmd wins if i_cmd_req=1 and (i_cpu_req=0 or starve>=CMD_STARVE).
    - otherwise cpu wins if i_cpu_req=1.
    - otherwise o_gnt=0, but the slot still runs (o_busy=1, no ack).
- On a slot start: cnt loads SLOT_LEN-1, state→ACCESS. o_we = winner's wr flag when cpu/cmd wins, else 0. o_gnt and o_we are latched and held for the whole slot.
- Starvation counter starve, 4 bits, saturating:
  - +1 when cpu wins a free slot while i_cmd_req=1.
  - cleared when cmd wins or when i_cmd_req=0 at a slot start.
- Ack: the owner's ack is high during the enabled cycle where cnt==0 (last cycle of the slot). It fires even if the requester dropped req mid-slot.
- Requester rule: req must be held until ack, and dropped on the enabled cycle after ack unless a new access is wanted. A request dropped before being granted is simply not served.
- i_slot_start while in ACCESS with cnt!=0: ignored, the current slot continues, o_ovr←1 (sticky until reset).
- Reset (async, any time, including mid-slot): state IDLE, cnt=0, starve=0. All outputs 0: o_gnt=0, o_we=0, both acks 0, o_busy=0, o_ovr=0. No ack is issued for an aborted slot.

## Timing
- Grant latency: o_gnt, o_we and o_busy are registered and valid from the enabled edge that samples i_slot_start. They hold exactly SLOT_LEN enabled cycles.
- Ack is registered and coincides with the last grant cycle.
- End of slot: on the next enabled edge the block returns to IDLE. If i_slot_start=1 on that edge instead, a new slot starts back-to-back with no idle gap; o_gnt switches directly to the new owner.
- Disabled cycles (i_phiA_NCEN=0) freeze all state and outputs.
- Request inputs and i_slot_type are sampled only on the slot-start edge.

## Test plan
- Reset mid-slot: cpu slot running with cnt=3, assert i_HRST_n=0 → all outputs 0 immediately; after release, next free slot_start with cpu_req=1 → o_gnt=0100 for 8 cycles, o_cpu_ack on cycle 8 only.
- Slot types: types 01, 10, 11 with i_disp_en=1 → o_gnt 0001, 0010, 0001, no acks. Type 01 with i_disp_en=0 and cmd_req=1 → o_gnt=1000, o_cmd_ack pulses.
- Starvation: cpu_req and cmd_req held high over 6 free slots (CMD_STARVE=2) → owners cpu, cpu, cmd, cpu, cpu, cmd.
- Back-to-back: slot_start on the cnt==0 edge → new grant begins on the next enabled cycle, o_busy stays 1, ack pulses exactly once per slot.
- Overrun: slot_start at cnt=4 → ignored, slot length unchanged, o_ovr=1 and held through later slots until reset.
- Clock enable gaps: i_phiA_NCEN toggling 1,0,0,1… during a write slot with i_cmd_wr=1 → o_we=1 across exactly 8 enabled cycles; ack width is one enabled cycle, held across disabled cycles.
